// File: rtl/noc_read_buffer.sv
// NoC egress read buffer: small FIFO between the NoC egress port and a processor read conduit.
// Optional saturating drop counter (ovf_cnt) is built only when NOC_READ_BUFFER_OVF_CNT_EN is defined.
module noc_read_buffer #(
    parameter int DEPTH = 4,
    parameter int CW    = 3
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [31:0]   noc_in,
    input  logic          rd_ack,
    input  logic          clr_ovf,
    output logic [31:0]   rd_data,
    output logic [CW-1:0] count,
    output logic          full,
`ifdef NOC_READ_BUFFER_OVF_CNT_EN
    output logic [7:0]    ovf_cnt,
`endif
    output logic          ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [30:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_ovf;
`ifdef NOC_READ_BUFFER_OVF_CNT_EN
    logic [7:0]    r_ovf_cnt;
`endif

    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_full;
    logic w_not_empty;

    // A full FIFO still accepts a word when the same cycle frees a slot.
    always_comb begin
        w_not_empty = (r_count != '0);
        w_full      = (r_count == CW'(DEPTH));
        w_pop       = rd_ack && w_not_empty;
        w_push      = noc_in[31] && (!w_full || w_pop);
        w_drop      = noc_in[31] && w_full && !w_pop;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_drop)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

`ifdef NOC_READ_BUFFER_OVF_CNT_EN
    // Clear and a coincident drop leave the counter at one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_cnt <= '0;
        end else if (clr_ovf) begin
            r_ovf_cnt <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_ovf_cnt != 8'hFF)) begin
            r_ovf_cnt <= r_ovf_cnt + 8'd1;
        end
    end

    assign ovf_cnt = r_ovf_cnt;
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= noc_in[30:0];
    end

    assign rd_data = {w_not_empty, w_not_empty ? r_mem[r_rptr] : 31'd0};
    assign count   = r_count;
    assign full    = w_full;
    assign ovf     = r_ovf;

endmodule
